// File: rtl/mem_access_unit.sv
// Data-memory access stage: word loads/stores, byte loads with extension and
// byte stores via read-modify-write, against a variable-latency word memory.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  memwrite,
    input  logic [1:0]  ltype,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [7:0]  byte_q;
    logic [1:0]  ltype_q;
    logic [7:0]  cnt;

    logic [7:0]  lane;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        bad_req;
    logic        timeout_hit;

    always_comb begin
        lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        case (ltype_q)
            2'b01:   load_val = {24'h000000, lane};
            2'b10:   load_val = {{24{lane[7]}}, lane};
            default: load_val = mem_rdata;
        endcase
        merged = mem_rdata;
        merged[{addr_q[1:0], 3'b000} +: 8] = byte_q;
        // Word-sized accesses must be aligned; byte loads/stores may use any lane.
        bad_req = (memwrite == 2'b11) ||
                  (((memwrite == 2'b01) ||
                    ((memwrite == 2'b00) && (ltype[1] == ltype[0]))) &&
                   (addr[1:0] != 2'b00));
        timeout_hit = (cnt == 8'(TIMEOUT - 1));
    end

    assign busy     = (state != IDLE);
    assign state_o  = state;
    assign mem_addr = busy ? addr_q[31:2] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            byte_q    <= '0;
            ltype_q   <= '0;
            cnt       <= '0;
            rdata     <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= addr;
                        byte_q  <= wdata[7:0];
                        ltype_q <= ltype;
                        cnt     <= '0;
                        if (bad_req) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (memwrite == 2'b00) begin
                            state  <= RD;
                            mem_re <= 1'b1;
                        end else if (memwrite == 2'b01) begin
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= wdata;
                        end else begin
                            state  <= RMW_RD;
                            mem_re <= 1'b1;
                        end
                    end
                end
                RD, RMW_RD: begin
                    if (mem_ready) begin
                        mem_re <= 1'b0;
                        if (state == RD) begin
                            rdata <= load_val;
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RMW_WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= merged;
                            cnt       <= '0;
                        end
                    end else if (timeout_hit) begin
                        mem_re <= 1'b0;
                        state  <= DONE;
                        done   <= 1'b1;
                        err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WR, RMW_WR: begin
                    if (mem_ready || timeout_hit) begin
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        state     <= DONE;
                        done      <= 1'b1;
                        err       <= !mem_ready;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model predicting latency,
// strobes and results per request, checked every cycle on the falling edge.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  memwrite = '0;
    logic [1:0]  ltype = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
        .ltype(ltype), .addr(addr), .wdata(wdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rdata(rdata),
        .busy(busy), .done(done), .err(err), .state_o(state_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: ready after wait_n low cycles of each strobe phase.
    int          wait_n = 0;
    logic [31:0] rd_word = '0;
    int          seen = 0;
    logic [1:0]  prev_kind = '0;
    logic [1:0]  cur_kind;
    assign mem_rdata = rd_word;

    always @(negedge clk) begin
        cur_kind = {mem_we, mem_re};
        if (cur_kind != 2'b00 && cur_kind == prev_kind) seen = seen + 1;
        else seen = 0;
        prev_kind = cur_kind;
        mem_ready = (wait_n == 0) || (cur_kind != 2'b00 && seen >= wait_n);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected transaction, written only by the driver.
    bit          act = 1'b0;
    bit          rst_test = 1'b0;
    int          start_cyc = 0;
    int          lat = 0;
    int          c1 = 0;
    int          c2 = 0;
    bit          ph1_wr = 1'b0;
    bit          e_err = 1'b0;
    bit          ld_upd = 1'b0;
    logic [29:0] e_addr = '0;
    logic [31:0] e_wd1 = '0;
    logic [31:0] e_wd2 = '0;
    logic [31:0] e_ld = '0;

    // Written only by the compare process.
    logic [31:0] rdata_model = '0;
    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] last_wdata = '0;
    int          n;
    logic        ex_re, ex_we, ex_done, ex_err, ex_busy;

    always @(negedge clk) begin
        if (rst_test) begin
            rdata_model = '0;
        end else begin
            n = act ? (cyc - start_cyc + 1) : 0;
            ex_busy = (n >= 1) && (n <= lat);
            ex_re   = ex_busy && (n <= c1) && !ph1_wr;
            ex_we   = ex_busy && (((n <= c1) && ph1_wr) || ((n > c1) && (n <= c1 + c2)));
            ex_done = ex_busy && (n == lat);
            ex_err  = ex_done && e_err;
            if (ex_done && ld_upd) rdata_model = e_ld;
            chk("busy", busy, ex_busy);
            chk("done", done, ex_done);
            chk("err", err, ex_err);
            chk("mem_re", mem_re, ex_re);
            chk("mem_we", mem_we, ex_we);
            chk("rdata", rdata, rdata_model);
            if (!ex_busy) chk("state_idle", state_o, 0);
            if (ex_re || ex_we) chk("mem_addr", mem_addr, e_addr);
            if (ex_we) chk("mem_wdata", mem_wdata, (n <= c1) ? e_wd1 : e_wd2);
            if (mem_re) re_cnt++;
            if (mem_we) begin
                we_cnt++;
                last_wdata = mem_wdata;
            end
        end
    end

    int re_base = 0;
    int we_base = 0;

    task automatic run(input logic [1:0] mw, input logic [1:0] lt, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int wn,
                       input bit inject);
        int         k;
        int         ph_cyc;
        bit         to1;
        logic [7:0] b;
        @(posedge clk); #1;
        memwrite = mw; ltype = lt; addr = a; wdata = wd; rd_word = word; wait_n = wn;
        k = int'(a[1:0]);
        b = word[8*k +: 8];
        e_err = (mw == 2'd3) || ((mw == 2'd1 || (mw == 2'd0 && (lt == 2'd0 || lt == 2'd3))) && k != 0);
        e_addr = a[31:2];
        e_wd1 = wd;
        e_wd2 = (word & ~(32'hFF << (8 * k))) | ({24'h0, wd[7:0]} << (8 * k));
        case (lt)
            2'd1:    e_ld = {24'h0, b};
            2'd2:    e_ld = b[7] ? {24'hFFFFFF, b} : {24'h0, b};
            default: e_ld = word;
        endcase
        if (wn + 1 <= TO) begin ph_cyc = wn + 1; to1 = 1'b0; end
        else begin ph_cyc = TO; to1 = 1'b1; end
        c1 = 0; c2 = 0; ld_upd = 1'b0; ph1_wr = (mw == 2'd1);
        if (!e_err) begin
            c1 = ph_cyc;
            if (to1) e_err = 1'b1;
            else if (mw == 2'd2) c2 = ph_cyc;
            ld_upd = (mw == 2'd0) && !to1;
        end
        lat = 1 + c1 + c2;
        re_base = re_cnt; we_base = we_cnt;
        start_cyc = cyc + 1;
        act = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        if (inject) begin
            memwrite = 2'b11; addr = 32'h3;
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (lat + 1) @(posedge clk);
        #1;
        act = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we_re", {mem_we, mem_re}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_state", state_o, 0);
        chk("rst_mem_addr", mem_addr, 0);
        #2 reset = 1'b1;

        run(2'd0, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        chk("lw_re_cycles", re_cnt - re_base, 1);
        run(2'd0, 2'd2, 32'h13, 32'h0, 32'h80FF1234, 0, 0);
        chk("lb_sext", rdata, 32'hFFFFFF80);
        run(2'd0, 2'd1, 32'h13, 32'h0, 32'h80FF1234, 0, 0);
        chk("lbu_zext", rdata, 32'h00000080);
        run(2'd0, 2'd2, 32'h11, 32'h0, 32'h80FF1234, 0, 0);
        chk("lb_lane1", rdata, 32'h00000012);
        run(2'd2, 2'd0, 32'h22, 32'hAB, 32'h11223344, 0, 0);
        chk("sb_merge", last_wdata, 32'h11AB3344);
        run(2'd1, 2'd0, 32'h06, 32'h55, 32'h0, 0, 0);
        chk("sw_mis_strobes", (re_cnt - re_base) + (we_cnt - we_base), 0);
        run(2'd3, 2'd0, 32'h08, 32'h55, 32'h0, 0, 0);
        chk("illegal_strobes", (re_cnt - re_base) + (we_cnt - we_base), 0);
        run(2'd1, 2'd0, 32'h40, 32'hCAFEF00D, 32'h0, 3, 0);
        chk("sw_wait_we_cycles", we_cnt - we_base, 4);
        chk("sw_wait_data", last_wdata, 32'hCAFEF00D);
        run(2'd0, 2'd0, 32'h44, 32'h0, 32'h77777777, 1000, 0);
        chk("lw_timeout_re_cycles", re_cnt - re_base, 4);
        chk("lw_timeout_rdata", rdata, 32'h00000012);
        run(2'd0, 2'd3, 32'h08, 32'h0, 32'h01234567, 1, 0);
        chk("lw_lt3_rdata", rdata, 32'h01234567);
        run(2'd2, 2'd0, 32'h23, 32'h1FE, 32'h11223344, 4, 0);
        chk("sb_timeout_no_write", we_cnt - we_base, 0);
        run(2'd2, 2'd0, 32'h20, 32'h55, 32'hAABBCCDD, 2, 0);
        chk("sb_wait_merge", last_wdata, 32'hAABBCC55);
        run(2'd0, 2'd1, 32'h02, 32'h0, 32'h00C30000, 0, 1);
        chk("busy_start_ignored", rdata, 32'h000000C3);
        run(2'd0, 2'd0, 32'h01, 32'h0, 32'h0, 0, 0);
        run(2'd0, 2'd3, 32'h03, 32'h0, 32'h0, 0, 0);

        @(posedge clk); #1;
        rst_test = 1'b1;
        memwrite = 2'd2; ltype = 2'd0; addr = 32'h22; wdata = 32'hAB;
        rd_word = 32'h11223344; wait_n = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rmw_wr_we", mem_we, 1);
        chk("rmw_wr_state", state_o, 4);
        reset = 1'b0;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_re", mem_re, 0);
        chk("arst_state", state_o, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        chk("arst_rdata", rdata, 0);
        #4 reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("arst_no_done", done, 0);
        end
        rst_test = 1'b0;

        run(2'd0, 2'd0, 32'h30, 32'h0, 32'h13579BDF, 0, 0);
        chk("post_rst_lw", rdata, 32'h13579BDF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
